// File: rtl/bram_cloud_loader.sv
// Producer side of the x/y/z point-cloud BRAM protocol: packs streamed points
// eight to a word, writes the frame header, launches the filter and waits for its mark.
module bram_cloud_loader #(
  parameter int          N          = 16,
  parameter int          LANES      = 8,
  parameter int          MAX_POINTS = 4096,
  parameter logic [15:0] DONE_MARK  = 16'h0fff
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_x,
  input  logic [N-1:0]         in_y,
  input  logic [N-1:0]         in_z,
  input  logic                 in_last,
  output logic [31:0]          addr_x,
  output logic [31:0]          addr_y,
  output logic [31:0]          addr_z,
  output logic [N*LANES-1:0]   write_in_x,
  output logic [N*LANES-1:0]   write_in_y,
  output logic [N*LANES-1:0]   write_in_z,
  input  logic [N*LANES-1:0]   read_out_x,
  input  logic [N*LANES-1:0]   read_out_y,
  input  logic [N*LANES-1:0]   read_out_z,
  output logic                 en_x,
  output logic                 en_y,
  output logic                 en_z,
  output logic                 rst_x,
  output logic                 rst_y,
  output logic                 rst_z,
  output logic [N*LANES/8-1:0] we_x,
  output logic [N*LANES/8-1:0] we_y,
  output logic [N*LANES/8-1:0] we_z,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [31:0]          point_count,
  output logic [2:0]           state
);

  localparam int W  = N * LANES;
  localparam int BE = W / 8;
  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);
  localparam logic [BE-1:0] WE_ALL   = '1;
  localparam logic [BE-1:0] WE_LO32  = BE'(4'hf);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HDR     = 3'd2,
    S_GO      = 3'd3,
    S_WAIT    = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lane_q;
  logic [31:0]   count_q;
  logic [31:0]   word_ptr_q;
  logic [31:0]   wr_addr_q;
  logic [W-1:0]  stage_x_q, stage_y_q, stage_z_q;
  logic [W-1:0]  wr_x_q, wr_y_q, wr_z_q;
  logic          wr_pend_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic          overflow_q;
  logic          poll_q;

  logic          accept, store, flush;
  logic [W-1:0]  merged_x, merged_y, merged_z;
  logic [W-1:0]  flush_x, flush_y, flush_z;
  logic          unused_rd;

  assign unused_rd = ^{read_out_x, read_out_y, read_out_z[W-1:16]};

  assign accept = (state_q == S_LOAD) && in_valid && !last_q;
  assign store  = accept && (count_q < 32'(MAX_POINTS));
  // A dropped in_last still has to push out whatever partial word is staged.
  assign flush  = accept && ((store && ((lane_q == LANE_MAX) || in_last)) ||
                             (!store && in_last && (lane_q != '0)));

  always_comb begin
    merged_x = stage_x_q;
    merged_y = stage_y_q;
    merged_z = stage_z_q;
    merged_x[int'(lane_q) * N +: N] = in_x;
    merged_y[int'(lane_q) * N +: N] = in_y;
    merged_z[int'(lane_q) * N +: N] = in_z;
    flush_x = store ? merged_x : stage_x_q;
    flush_y = store ? merged_y : stage_y_q;
    flush_z = store ? merged_z : stage_z_q;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD:    if (last_q) state_d = S_HDR;
      S_HDR:     state_d = S_GO;
      S_GO:      state_d = S_WAIT;
      S_WAIT:    if (poll_q && (read_out_z[15:0] == DONE_MARK)) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q     <= '0;
      count_q    <= '0;
      word_ptr_q <= 32'd1;
      wr_addr_q  <= '0;
      stage_x_q  <= '0;
      stage_y_q  <= '0;
      stage_z_q  <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_z_q     <= '0;
      wr_pend_q  <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      poll_q     <= 1'b0;
    end else begin
      wr_pend_q <= 1'b0;
      done_q    <= (state_q == S_RELEASE);
      // Read data is only meaningful if the previous cycle issued a poll.
      poll_q    <= (state_q == S_WAIT);
      case (state_q)
        S_IDLE: if (start) begin
          count_q    <= '0;
          lane_q     <= '0;
          overflow_q <= 1'b0;
          busy_q     <= 1'b1;
          last_q     <= 1'b0;
          word_ptr_q <= 32'd1;
          stage_x_q  <= '0;
          stage_y_q  <= '0;
          stage_z_q  <= '0;
        end
        S_LOAD: if (accept) begin
          if (in_last) last_q <= 1'b1;
          if (store) count_q <= count_q + 32'd1;
          else       overflow_q <= 1'b1;
          if (flush) begin
            wr_x_q     <= flush_x;
            wr_y_q     <= flush_y;
            wr_z_q     <= flush_z;
            wr_addr_q  <= word_ptr_q;
            wr_pend_q  <= 1'b1;
            word_ptr_q <= word_ptr_q + 32'd1;
            stage_x_q  <= '0;
            stage_y_q  <= '0;
            stage_z_q  <= '0;
            lane_q     <= '0;
          end else if (store) begin
            stage_x_q <= merged_x;
            stage_y_q <= merged_y;
            stage_z_q <= merged_z;
            lane_q    <= lane_q + 1'b1;
          end
        end
        S_RELEASE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state_q == S_LOAD) && !last_q;
    en_x       = 1'b0;
    en_y       = 1'b0;
    en_z       = 1'b0;
    we_x       = '0;
    we_y       = '0;
    we_z       = '0;
    addr_x     = '0;
    addr_y     = '0;
    addr_z     = '0;
    write_in_x = '0;
    write_in_y = '0;
    write_in_z = '0;
    case (state_q)
      S_LOAD: if (wr_pend_q) begin
        en_x = 1'b1; en_y = 1'b1; en_z = 1'b1;
        we_x = WE_ALL; we_y = WE_ALL; we_z = WE_ALL;
        addr_x = wr_addr_q; addr_y = wr_addr_q; addr_z = wr_addr_q;
        write_in_x = wr_x_q; write_in_y = wr_y_q; write_in_z = wr_z_q;
      end
      S_HDR: begin
        en_x       = 1'b1;
        we_x       = WE_LO32;
        write_in_x = {{(W-32){1'b0}}, count_q};
        en_z       = 1'b1;
        we_z       = WE_LO32;
      end
      S_GO: begin
        en_y       = 1'b1;
        we_y       = WE_LO32;
        write_in_y = W'(1);
      end
      S_WAIT:    en_z = 1'b1;
      S_RELEASE: begin
        en_y = 1'b1;
        we_y = WE_LO32;
      end
      default: ;
    endcase
  end

  assign rst_x       = 1'b0;
  assign rst_y       = 1'b0;
  assign rst_z       = 1'b0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign point_count = count_q;
  assign state       = state_q;

endmodule
